register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the width of each register and of each data port.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 5, meaning the register select width, giving 2**ADDR_WIDTH = 32 registers.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all writes occur on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port enable, input, 1 bit: write enable for port W.
REQ-006 The module SHALL have port RW, input, ADDR_WIDTH bits: write register select.
REQ-007 The module SHALL have port PW, input, DATA_WIDTH bits: write data.
REQ-008 The module SHALL have ports RA, RB and RD, each input, ADDR_WIDTH bits: read selects for ports A, B and D.
REQ-009 The module SHALL have ports PA, PB and PD, each output, DATA_WIDTH bits: read data for ports A, B and D.
REQ-010 The port order SHALL be clock, reset_n, enable, RW, PW, RA, PA, RB, PB, RD, PD.

Function
REQ-011 The module SHALL contain 32 registers, R0 to R31, each DATA_WIDTH bits wide.
REQ-012 Write behaviour SHALL be as follows:
- Condition: rising clock edge with reset_n=1 and enable=1.
- Action: register R[RW] loads PW.
- No other register changes.
REQ-013 With enable=0 at a rising edge, no register SHALL change.
REQ-014 Reads SHALL be combinational on all three ports: PA=R[RA], PB=R[RB], PD=R[RD].
REQ-015 Read timing SHALL be as follows:
- Ports A, B and D are independent.
- Any two or all three ports may select the same register at the same time.
- Read latency is zero cycles.
REQ-016 Read-during-write SHALL work as follows:
- A port that selects the register being written shows the old value until the rising edge.
- After the edge, the port shows the new value.
- There is no write-to-read bypass.
REQ-017 The select inputs SHALL have no wrap-around or out-of-range case; all 5-bit values are valid (R31 to R0 is an ordinary index change).
REQ-018 An X or Z value on RW while enable=1 SHALL NOT be required to leave state intact; testbenches must drive RW to a known value.

Reset
REQ-019 While reset_n=0, all 32 registers SHALL be 0 immediately, independent of clock.
REQ-020 While reset_n=0, PA, PB and PD SHALL be 0.
REQ-021 Reset SHALL take priority over writes; a write on the same edge as active reset is discarded.
REQ-022 Registers SHALL accept writes from the first rising edge after reset_n returns high.
REQ-023 Deasserting reset_n mid-operation SHALL leave registers at 0; no pending write completes.

Configuration
REQ-024 The module SHALL support macro REGFILE_R0_ZERO_EN with the following behaviour:
- Defined: R0 is hardwired to 0; writes to RW=0 are ignored; any port selecting 0 reads 0.
- Not defined: R0 is an ordinary writable register like R1 to R31.

Verification
REQ-025 Reset test: reset_n=0 with arbitrary RA, RB, RD -> PA=PB=PD=0 immediately, without a clock edge.
REQ-026 Sweep test:
- Stimulus: enable=1, RW=n, PW=20+n for n=0..31, one write per clock; afterwards read RA=n, RB=n+31 mod 32, RD=n+30 mod 32.
- Required response: each port returns 20+index, except index 0, which returns 0 if REGFILE_R0_ZERO_EN is defined and 20 otherwise.
REQ-027 Write-enable test: write R5=0x1234, then enable=0 with PW=0xFFFF_FFFF and RW=5 for 2 edges -> PA (RA=5) stays 0x1234.
REQ-028 Read-during-write test: R7=10, then write PW=99 to R7 with RA=7 -> PA=10 before the edge and 99 after it.
REQ-029 Triple-read test: RA=RB=RD=12 after R12=0xDEAD_BEEF -> all three ports read 0xDEAD_BEEF.
REQ-030 Reset-during-operation test: R3=55, then pulse reset_n low between edges -> PA (RA=3)=0 at once, and 0 after reset_n rises until R3 is rewritten.

Source files
------------

// File: rtl/register_file.sv
// 32-entry register file: one synchronous write port, three combinational read ports.
// Define REGFILE_R0_ZERO_EN to hardwire R0 to zero.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] RW,
  input  logic [DATA_WIDTH-1:0] PW,
  input  logic [ADDR_WIDTH-1:0] RA,
  output logic [DATA_WIDTH-1:0] PA,
  input  logic [ADDR_WIDTH-1:0] RB,
  output logic [DATA_WIDTH-1:0] PB,
  input  logic [ADDR_WIDTH-1:0] RD,
  output logic [DATA_WIDTH-1:0] PD
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Each register is its own flop bank so the async clear reaches every
  // entry at once and reads can stay purely combinational.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
`ifdef REGFILE_R0_ZERO_EN
    if (gi == 0) begin : g_zero
      assign regs[gi] = '0;
    end else begin : g_store
`else
    begin : g_store
`endif
      logic [DATA_WIDTH-1:0] value_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          value_reg <= '0;
        end else if (enable && (RW == ADDR_WIDTH'(gi))) begin
          value_reg <= PW;
        end
      end

      assign regs[gi] = value_reg;
    end
  end

  assign PA = regs[RA];
  assign PB = regs[RB];
  assign PD = regs[RD];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (honours REGFILE_R0_ZERO_EN if defined).
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [4:0]  RW, RA, RB, RD;
  logic [31:0] PW, PA, PB, PD;

  int compared   = 0;
  int mismatched = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .RW      (RW),
    .PW      (PW),
    .RA      (RA),
    .PA      (PA),
    .RB      (RB),
    .PB      (PB),
    .RD      (RD),
    .PD      (PD)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] sweep_val(input int idx);
`ifdef REGFILE_R0_ZERO_EN
    if (idx == 0) return 32'd0;
`endif
    return 32'(20 + idx);
  endfunction

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    RW = 5'd0; PW = 32'd0;
    RA = 5'd3; RB = 5'd17; RD = 5'd31;
    #1;
    check("reset_pa", PA, 32'd0);
    check("reset_pb", PB, 32'd0);
    check("reset_pd", PD, 32'd0);

    tick();
    #2 reset_n = 1'b1;

    // Sweep: write 20+n into every register, one per clock.
    enable = 1'b1;
    for (int n = 0; n < 32; n++) begin
      RW = 5'(n);
      PW = 32'(20 + n);
      tick();
    end
    enable = 1'b0;
    for (int n = 0; n < 32; n++) begin
      RA = 5'(n);
      RB = 5'((n + 31) % 32);
      RD = 5'((n + 30) % 32);
      #1;
      check($sformatf("sweep_pa[%0d]", n), PA, sweep_val(n));
      check($sformatf("sweep_pb[%0d]", (n + 31) % 32), PB, sweep_val((n + 31) % 32));
      check($sformatf("sweep_pd[%0d]", (n + 30) % 32), PD, sweep_val((n + 30) % 32));
    end

    // Write enable low must hold the register.
    enable = 1'b1; RW = 5'd5; PW = 32'h0000_1234;
    tick();
    enable = 1'b0; PW = 32'hFFFF_FFFF;
    tick();
    tick();
    RA = 5'd5;
    #1;
    check("wen_hold_r5", PA, 32'h0000_1234);
    RB = 5'd6;
    #1;
    check("wen_r6_untouched", PB, 32'd26);

    // Read during write: old value until the edge, new value after.
    enable = 1'b1; RW = 5'd7; PW = 32'd10;
    tick();
    PW = 32'd99; RA = 5'd7;
    #1;
    check("rdw_before_edge", PA, 32'd10);
    tick();
    check("rdw_after_edge", PA, 32'd99);
    enable = 1'b0;

    // Three ports on the same register.
    enable = 1'b1; RW = 5'd12; PW = 32'hDEAD_BEEF;
    tick();
    enable = 1'b0;
    RA = 5'd12; RB = 5'd12; RD = 5'd12;
    #1;
    check("triple_pa", PA, 32'hDEAD_BEEF);
    check("triple_pb", PB, 32'hDEAD_BEEF);
    check("triple_pd", PD, 32'hDEAD_BEEF);

    // Reset in the middle of operation, with a write attempted while low.
    enable = 1'b1; RW = 5'd3; PW = 32'd55;
    tick();
    enable = 1'b0; RA = 5'd3; RB = 5'd12;
    #1;
    check("r3_loaded", PA, 32'd55);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_pa", PA, 32'd0);
    check("midreset_pb", PB, 32'd0);
    enable = 1'b1; RW = 5'd3; PW = 32'd77;
    tick();
    check("write_during_reset", PA, 32'd0);
    enable = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    check("after_reset_r3", PA, 32'd0);
    check("after_reset_r12", PB, 32'd0);
    enable = 1'b1; RW = 5'd3; PW = 32'd66;
    tick();
    enable = 1'b0;
    check("first_write_after_reset", PA, 32'd66);

    // R0 write behaviour depends on the configuration.
    enable = 1'b1; RW = 5'd0; PW = 32'hA5A5_A5A5; RD = 5'd0;
    tick();
    enable = 1'b0;
`ifdef REGFILE_R0_ZERO_EN
    check("r0_write", PD, 32'd0);
`else
    check("r0_write", PD, 32'hA5A5_A5A5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
